// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates conditional compares and JAL/JALR,
// checks against the front-end prediction, and registers one result entry.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_target,
   output logic [XLEN-1:0]  out_link,
   output logic             out_redirect,
   output logic [XLEN-1:0]  out_redirect_pc,
   output logic             out_illegal,
   output logic [CNT_W-1:0] cnt_branches,
   output logic [CNT_W-1:0] cnt_mispredicts
);

   localparam logic [1:0] KIND_BRANCH = 2'd0;
   localparam logic [1:0] KIND_JAL    = 2'd1;
   localparam logic [1:0] KIND_JALR   = 2'd2;

   logic             valid_reg;
   logic             taken_reg;
   logic [XLEN-1:0]  target_reg;
   logic [XLEN-1:0]  link_reg;
   logic             redirect_reg;
   logic [XLEN-1:0]  redirect_pc_reg;
   logic             illegal_reg;
   logic [CNT_W-1:0] cnt_branches_reg;
   logic [CNT_W-1:0] cnt_mispredicts_reg;

   logic             accept;
   logic             retire;
   logic             cond_next;
   logic             cond_legal;
   logic             taken_next;
   logic             illegal_next;
   logic [XLEN-1:0]  link_next;
   logic [XLEN-1:0]  pc_imm;
   logic [XLEN-1:0]  rs1_imm;
   logic [XLEN-1:0]  target_next;
   logic             redirect_next;
   logic [XLEN-1:0]  redirect_pc_next;

   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   // A flushed entry never counts as retired, even if the consumer was ready.
   assign retire   = valid_reg && out_ready && !flush;

   assign link_next = in_pc + XLEN'(4);
   assign pc_imm    = in_pc + in_imm;
   assign rs1_imm   = in_rs1 + in_imm;

   always_comb begin
      cond_next  = 1'b0;
      cond_legal = 1'b1;
      case (in_funct3)
         3'd0:    cond_next = (in_rs1 == in_rs2);
         3'd1:    cond_next = (in_rs1 != in_rs2);
         3'd4:    cond_next = ($signed(in_rs1) <  $signed(in_rs2));
         3'd5:    cond_next = ($signed(in_rs1) >= $signed(in_rs2));
         3'd6:    cond_next = (in_rs1 <  in_rs2);
         3'd7:    cond_next = (in_rs1 >= in_rs2);
         default: cond_legal = 1'b0;
      endcase
   end

   always_comb begin
      taken_next   = 1'b0;
      illegal_next = 1'b0;
      target_next  = link_next;
      case (in_kind)
         KIND_BRANCH: begin
            if (cond_legal) begin
               taken_next  = cond_next;
               target_next = pc_imm;
            end else begin
               illegal_next = 1'b1;
            end
         end
         KIND_JAL: begin
            taken_next  = 1'b1;
            target_next = pc_imm;
         end
         KIND_JALR: begin
            taken_next  = 1'b1;
            target_next = {rs1_imm[XLEN-1:1], 1'b0};
         end
         default: illegal_next = 1'b1;
      endcase
   end

   // Illegal entries resolve as not-taken, so the equations below need no special case.
   assign redirect_next    = (in_pred_taken != taken_next) ||
                             (taken_next && (in_pred_target != target_next));
   assign redirect_pc_next = taken_next ? target_next : link_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (accept) begin
         valid_reg <= 1'b1;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_reg       <= 1'b0;
         target_reg      <= '0;
         link_reg        <= '0;
         redirect_reg    <= 1'b0;
         redirect_pc_reg <= '0;
         illegal_reg     <= 1'b0;
      end else if (accept) begin
         taken_reg       <= taken_next;
         target_reg      <= target_next;
         link_reg        <= link_next;
         redirect_reg    <= redirect_next;
         redirect_pc_reg <= redirect_pc_next;
         illegal_reg     <= illegal_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_branches_reg    <= '0;
         cnt_mispredicts_reg <= '0;
      end else if (retire) begin
         if (cnt_branches_reg != {CNT_W{1'b1}}) begin
            cnt_branches_reg <= cnt_branches_reg + CNT_W'(1);
         end
         if (redirect_reg && (cnt_mispredicts_reg != {CNT_W{1'b1}})) begin
            cnt_mispredicts_reg <= cnt_mispredicts_reg + CNT_W'(1);
         end
      end
   end

   assign out_valid       = valid_reg;
   assign out_taken       = taken_reg;
   assign out_target      = target_reg;
   assign out_link        = link_reg;
   assign out_redirect    = redirect_reg;
   assign out_redirect_pc = redirect_pc_reg;
   assign out_illegal     = illegal_reg;
   assign cnt_branches    = cnt_branches_reg;
   assign cnt_mispredicts = cnt_mispredicts_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: a vector table streamed back-to-back, then hand-written
// stall, flush, async-reset and counter-saturation sequences.
module tb_branch_resolve_unit;

   localparam int XLEN = 32;
   localparam int NV   = 15;

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  funct3;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        pt;
      logic [31:0] ptgt;
      logic        e_taken;
      logic [31:0] e_target;
      logic [31:0] e_link;
      logic        e_redir;
      logic [31:0] e_rpc;
      logic        e_ill;
   } vec_t;

   vec_t tbl [NV];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  in_kind = '0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pred_target = '0;
   logic        in_pred_taken = 1'b0;

   logic        in_ready, out_valid, out_taken, out_redirect, out_illegal;
   logic [31:0] out_target, out_link, out_redirect_pc, cnt_branches, cnt_mispredicts;

   logic        in_ready2, out_valid2, out_taken2, out_redirect2, out_illegal2;
   logic [31:0] out_target2, out_link2, out_redirect_pc2;
   logic [1:0]  cnt_branches2, cnt_mispredicts2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
      .in_pred_target(in_pred_target), .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
      .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
      .out_illegal(out_illegal), .cnt_branches(cnt_branches),
      .cnt_mispredicts(cnt_mispredicts)
   );

   // Narrow-counter copy sharing the same traffic, used for saturation checks.
   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
      .in_pred_target(in_pred_target), .out_valid(out_valid2), .out_ready(out_ready),
      .out_taken(out_taken2), .out_target(out_target2), .out_link(out_link2),
      .out_redirect(out_redirect2), .out_redirect_pc(out_redirect_pc2),
      .out_illegal(out_illegal2), .cnt_branches(cnt_branches2),
      .cnt_mispredicts(cnt_mispredicts2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input int i, input logic [1:0] k, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] lnk,
                      input logic rd, input logic [31:0] rpc, input logic il);
      tbl[i].kind = k;     tbl[i].funct3 = f3;  tbl[i].pc = pc;
      tbl[i].rs1 = rs1;    tbl[i].rs2 = rs2;    tbl[i].imm = imm;
      tbl[i].pt = pt;      tbl[i].ptgt = ptgt;  tbl[i].e_taken = tk;
      tbl[i].e_target = tgt; tbl[i].e_link = lnk; tbl[i].e_redir = rd;
      tbl[i].e_rpc = rpc;  tbl[i].e_ill = il;
   endtask

   task automatic drive(input int i);
      in_kind = tbl[i].kind;      in_funct3 = tbl[i].funct3;
      in_pc = tbl[i].pc;          in_rs1 = tbl[i].rs1;
      in_rs2 = tbl[i].rs2;        in_imm = tbl[i].imm;
      in_pred_taken = tbl[i].pt;  in_pred_target = tbl[i].ptgt;
   endtask

   task automatic check_entry(input int i);
      check($sformatf("v%0d valid", i),    {31'd0, out_valid},    32'd1);
      check($sformatf("v%0d taken", i),    {31'd0, out_taken},    {31'd0, tbl[i].e_taken});
      check($sformatf("v%0d target", i),   out_target,            tbl[i].e_target);
      check($sformatf("v%0d link", i),     out_link,              tbl[i].e_link);
      check($sformatf("v%0d redirect", i), {31'd0, out_redirect}, {31'd0, tbl[i].e_redir});
      check($sformatf("v%0d rpc", i),      out_redirect_pc,       tbl[i].e_rpc);
      check($sformatf("v%0d illegal", i),  {31'd0, out_illegal},  {31'd0, tbl[i].e_ill});
   endtask

   initial begin
      int exp_br;
      int exp_mis;
      //      i  k  f3  pc            rs1           rs2           imm           pt ptgt         tk tgt          link         rd rpc          il
      add( 0, 0, 0, 32'h100,      32'd5,        32'd5,        32'h20,       0, 32'h0,      1, 32'h120,     32'h104,     1, 32'h120,     0); // BEQ
      add( 1, 0, 4, 32'h200,      32'hFFFFFFFF, 32'd1,        32'h40,       1, 32'h240,    1, 32'h240,     32'h204,     0, 32'h240,     0); // BLT
      add( 2, 0, 6, 32'h200,      32'hFFFFFFFF, 32'd1,        32'h40,       1, 32'h240,    0, 32'h240,     32'h204,     1, 32'h204,     0); // BLTU
      add( 3, 2, 0, 32'h300,      32'h1003,     32'd0,        32'h0,        1, 32'h1002,   1, 32'h1002,    32'h304,     0, 32'h1002,    0); // JALR
      add( 4, 0, 1, 32'h400,      32'd3,        32'd3,        32'hFFFFFFF0, 0, 32'h0,      0, 32'h3F0,     32'h404,     0, 32'h404,     0); // BNE
      add( 5, 0, 5, 32'h500,      32'hFFFFFFFF, 32'd1,        32'h10,       0, 32'h0,      0, 32'h510,     32'h504,     0, 32'h504,     0); // BGE
      add( 6, 0, 7, 32'h600,      32'hFFFFFFFF, 32'd1,        32'h10,       1, 32'h600,    1, 32'h610,     32'h604,     1, 32'h610,     0); // BGEU
      add( 7, 1, 0, 32'hFFFFFFFC, 32'd0,        32'd0,        32'h8,        1, 32'h4,      1, 32'h4,       32'h0,       0, 32'h4,       0); // JAL wrap
      add( 8, 0, 2, 32'h800,      32'd1,        32'd1,        32'h20,       1, 32'h820,    0, 32'h804,     32'h804,     1, 32'h804,     1); // f3=2
      add( 9, 3, 0, 32'h900,      32'd0,        32'd0,        32'h20,       0, 32'h0,      0, 32'h904,     32'h904,     0, 32'h904,     1); // kind 3
      add(10, 2, 0, 32'hA00,      32'hFFFFFFFF, 32'd0,        32'h2,        1, 32'h0,      1, 32'h0,       32'hA04,     0, 32'h0,       0); // JALR wrap
      add(11, 0, 4, 32'hB00,      32'd1,        32'hFFFFFFFF, 32'h8,        1, 32'hB08,    0, 32'hB08,     32'hB04,     1, 32'hB04,     0); // BLT
      add(12, 0, 0, 32'hC00,      32'd1,        32'd2,        32'h4,        0, 32'h0,      0, 32'hC04,     32'hC04,     0, 32'hC04,     0); // BEQ nt
      add(13, 1, 0, 32'h10,       32'd0,        32'd0,        32'h100,      1, 32'h114,    1, 32'h110,     32'h14,      1, 32'h110,     0); // JAL tgt miss
      add(14, 0, 6, 32'hD00,      32'd1,        32'hFFFFFFFF, 32'hFFFFFF00, 0, 32'h0,      1, 32'hC00,     32'hD04,     1, 32'hC00,     0); // BLTU

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst target", out_target, 32'd0);
      check("rst cnt_br", cnt_branches, 32'd0);
      rst = 1'b0;
      #1;
      check("rst in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back stream with the consumer always ready
      out_ready = 1'b1;
      in_valid  = 1'b1;
      exp_br  = 0;
      exp_mis = 0;
      for (int i = 0; i < NV; i++) begin
         drive(i);
         @(posedge clk);
         #1;
         $display("vec %0d: taken=%0d target=%08h link=%08h redir=%0d rpc=%08h ill=%0d",
                  i, out_taken, out_target, out_link, out_redirect, out_redirect_pc, out_illegal);
         check_entry(i);
         check($sformatf("v%0d cnt_br", i), cnt_branches, exp_br);
         if (i == 2) check("sat pre cnt_br", {30'd0, cnt_branches2}, 32'd2);
         exp_br++;
         if (tbl[i].e_redir) exp_mis++;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("drain valid", {31'd0, out_valid}, 32'd0);
      check("drain cnt_br", cnt_branches, exp_br);
      check("drain cnt_mis", cnt_mispredicts, exp_mis);
      check("sat cnt_br", {30'd0, cnt_branches2}, 32'd3);
      check("sat cnt_mis", {30'd0, cnt_mispredicts2}, 32'd3);

      // Stall: entry held stable while out_ready=0
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(0);
      @(posedge clk);
      #1;
      check("stall valid", {31'd0, out_valid}, 32'd1);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      drive(1);
      @(posedge clk);
      #1;
      check("stall hold target", out_target, 32'h120);
      check("stall hold redir", {31'd0, out_redirect}, 32'd1);
      check("stall cnt_br", cnt_branches, exp_br);
      out_ready = 1'b1;
      #1;
      check("release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      exp_br++;
      exp_mis++;
      check("swap target", out_target, 32'h240);
      check("swap valid", {31'd0, out_valid}, 32'd1);
      check("swap cnt_br", cnt_branches, exp_br);
      check("swap cnt_mis", cnt_mispredicts, exp_mis);

      // Flush with a simultaneous accept: both entries are dropped
      drive(2);
      flush = 1'b1;
      #1;
      check("flush in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush valid", {31'd0, out_valid}, 32'd0);
      check("flush cnt_br", cnt_branches, exp_br);
      @(posedge clk);
      #1;
      check("flush discard valid", {31'd0, out_valid}, 32'd0);
      check("flush discard cnt_mis", cnt_mispredicts, exp_mis);

      // Asynchronous reset mid-transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(0);
      @(posedge clk);
      #1;
      check("pre-arst valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst valid", {31'd0, out_valid}, 32'd0);
      check("arst cnt_br", cnt_branches, 32'd0);
      check("arst target", out_target, 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post-arst valid", {31'd0, out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
